gf180mcu_fd_sc_mcu7t5v0__capbank_seq: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__capbank_pkg.sv | 37 +++
 rtl/gf180mcu_fd_sc_mcu7t5v0__capbank_dwell_cnt.sv | 47 ++++
 rtl/gf180mcu_fd_sc_mcu7t5v0__capbank_seq.sv | 153 +++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__capbank_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__capbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__capbank_pkg
// Brief    : Shared types and helpers for the switched-decap bank sequencer.
// Revision : 1.0  initial release
// ============================================================================
package gf180mcu_fd_sc_mcu7t5v0__capbank_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } state_e;

  // Largest supported bank and the count width needed to hold it
  localparam int C_MAX_NSEG  = 32;
  localparam int C_MAX_CNT_W = 6;

  // Width of a counter that must hold every value 0..nseg
  function automatic int cnt_width(input int nseg);
    return $clog2(nseg + 1);
  endfunction

  // Thermometer decode: bit i is set exactly when cnt > i
  function automatic logic [C_MAX_NSEG-1:0] therm_decode(input logic [C_MAX_CNT_W-1:0] cnt);
    logic [C_MAX_NSEG-1:0] mask;
    mask = '0;
    for (int i = 0; i < C_MAX_NSEG; i++) begin
      mask[i] = (int'(cnt) > i);
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__capbank_dwell_cnt.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__capbank_dwell_cnt
// Brief    : Loadable dwell down-counter with an expiry flag (count == 0).
//            The load value is captured only when load_i is asserted, so a
//            change on the dwell input never disturbs a step in progress.
// Revision : 1.0  initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__capbank_dwell_cnt
  import gf180mcu_fd_sc_mcu7t5v0__capbank_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk_i,
  input  logic               rn_i,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [DWELL_W-1:0] dc_q;
  logic [DWELL_W-1:0] dc_d;

  // Next count: load wins over decrement; decrement saturates at zero
  always_comb begin
    dc_d = dc_q;
    if (load_i) begin
      dc_d = load_val_i;
    end else if (dec_i && (dc_q != '0)) begin
      dc_d = dc_q - DWELL_W'(1);
    end
  end

  // Count register, cleared asynchronously with the rest of the bank
  always_ff @(posedge clk_i or negedge rn_i) begin
    if (!rn_i) begin
      dc_q <= '0;
    end else begin
      dc_q <= dc_d;
    end
  end

  assign zero_o = (dc_q == '0);

endmodule
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__capbank_seq.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__capbank_seq
// Brief    : Switched-decap bank sequencer. Ramps NSEG segments on or off one
//            at a time, one step every DWELL+1 cycles, and reports READY
//            (fully on) and IDLE (fully off).
// Revision : 1.0  initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__capbank_seq
  import gf180mcu_fd_sc_mcu7t5v0__capbank_pkg::*;
#(
  parameter int NSEG    = 8,
  parameter int DWELL_W = 4
) (
  input  logic               CLK,
  input  logic               RN,
  inout  wire                VDD,
  inout  wire                VSS,
  input  logic               EN,
  input  logic [DWELL_W-1:0] DWELL,
  output logic [NSEG-1:0]    SEG_EN,
  output logic               READY,
  output logic               IDLE
);

  localparam int            CW     = cnt_width(NSEG);
  localparam logic [CW-1:0] C_NSEG = CW'(NSEG);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q;
  logic          idle_q;

  logic          w_dc_zero;
  logic          w_dc_load;
  logic          w_dc_dec;

  // Supplies are pass-through pins on this cell; nothing inside consumes them
  wire w_supply_unused = VDD ^ VSS;

  // Dwell counter control: reload at every step and every direction change,
  // otherwise count down while a ramp is in progress
  always_comb begin
    w_dc_load = 1'b0;
    w_dc_dec  = 1'b0;
    case (state_q)
      ST_OFF: begin
        w_dc_load = EN;
      end
      ST_UP: begin
        if (!EN) begin
          w_dc_load = 1'b1;
        end else if (w_dc_zero) begin
          w_dc_load = (cnt_q < C_NSEG);
        end else begin
          w_dc_dec = 1'b1;
        end
      end
      ST_ON: begin
        w_dc_load = !EN;
      end
      ST_DOWN: begin
        if (EN) begin
          w_dc_load = 1'b1;
        end else if (w_dc_zero) begin
          w_dc_load = (cnt_q != '0);
        end else begin
          w_dc_dec = 1'b1;
        end
      end
      default: begin
        w_dc_load = 1'b0;
        w_dc_dec  = 1'b0;
      end
    endcase
  end

  gf180mcu_fd_sc_mcu7t5v0__capbank_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell_cnt (
    .clk_i      (CLK),
    .rn_i       (RN),
    .load_i     (w_dc_load),
    .load_val_i (DWELL),
    .dec_i      (w_dc_dec),
    .zero_o     (w_dc_zero)
  );

  // Sequencer FSM with segment count and registered status flags
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (EN) begin
            state_q <= ST_UP;
            cnt_q   <= C_ONE;
            idle_q  <= 1'b0;
          end
        end
        ST_UP: begin
          if (!EN) begin
            // Reversal: keep the count, first removal at the next expiry
            state_q <= ST_DOWN;
          end else if (w_dc_zero) begin
            if (cnt_q < C_NSEG) begin
              cnt_q <= cnt_q + C_ONE;
            end else begin
              state_q <= ST_ON;
              ready_q <= 1'b1;
            end
          end
        end
        ST_ON: begin
          if (!EN) begin
            // The top segment drops on the same edge that leaves ON
            state_q <= ST_DOWN;
            ready_q <= 1'b0;
            cnt_q   <= C_NSEG - C_ONE;
          end
        end
        ST_DOWN: begin
          if (EN) begin
            // Reversal: keep the count (even zero), next addition at expiry
            state_q <= ST_UP;
          end else if (w_dc_zero) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - C_ONE;
            end else begin
              state_q <= ST_OFF;
              idle_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_OFF;
        end
      endcase
    end
  end

  // Enables come only from the registered count, so each bit is glitch-free
  assign SEG_EN = NSEG'(therm_decode(C_MAX_CNT_W'(cnt_q)));
  assign READY  = ready_q;
  assign IDLE   = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__capbank_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_fd_sc_mcu7t5v0__capbank_seq
// Brief    : Directed self-checking bench for the decap bank sequencer.
//            One 4-segment and one 8-segment instance share clock and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu7t5v0__capbank_seq;

  typedef struct {
    logic [7:0] seg;
    logic       rdy;
    logic       idl;
  } exp_t;

  logic       clk;
  logic       rn;
  logic       en4;
  logic       en8;
  logic [3:0] dw4;
  logic [3:0] dw8;
  logic [3:0] seg4;
  logic [7:0] seg8;
  logic       rdy4, idl4, rdy8, idl8;
  wire        vdd;
  wire        vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  gf180mcu_fd_sc_mcu7t5v0__capbank_seq #(.NSEG(4), .DWELL_W(4)) u_dut4 (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .EN(en4), .DWELL(dw4),
    .SEG_EN(seg4), .READY(rdy4), .IDLE(idl4)
  );

  gf180mcu_fd_sc_mcu7t5v0__capbank_seq #(.NSEG(8), .DWELL_W(4)) u_dut8 (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .EN(en8), .DWELL(dw8),
    .SEG_EN(seg8), .READY(rdy8), .IDLE(idl8)
  );

  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the given observation
  task automatic compare(input logic [7:0] seg, input logic rdy, input logic idl, input string tag);
    exp_t e;
    e = sb.pop_front();
    n_cmp++;
    assert ({seg, rdy, idl} === {e.seg, e.rdy, e.idl})
    else begin
      n_err++;
      $error("FAIL %s: observed seg=%h ready=%b idle=%b, expected seg=%h ready=%b idle=%b",
             tag, seg, rdy, idl, e.seg, e.rdy, e.idl);
    end
  endtask

  task automatic push(input logic [7:0] seg, input logic rdy, input logic idl);
    exp_t e;
    e.seg = seg;
    e.rdy = rdy;
    e.idl = idl;
    sb.push_back(e);
  endtask

  // Expect n consecutive post-edge observations on the 4-segment instance
  task automatic hold4(input int n, input logic [3:0] seg, input logic rdy, input logic idl, input string tag);
    for (int k = 0; k < n; k++) begin
      push({4'b0, seg}, rdy, idl);
      @(posedge clk);
      #1;
      compare({4'b0, seg4}, rdy4, idl4, tag);
    end
  endtask

  // Expect n consecutive post-edge observations on the 8-segment instance
  task automatic hold8(input int n, input logic [7:0] seg, input logic rdy, input logic idl, input string tag);
    for (int k = 0; k < n; k++) begin
      push(seg, rdy, idl);
      @(posedge clk);
      #1;
      compare(seg8, rdy8, idl8, tag);
    end
  endtask

  initial begin
    int m;
    clk   = 1'b0;
    rn    = 1'b0;
    en4   = 1'b0;
    en8   = 1'b0;
    dw4   = 4'd2;
    dw8   = 4'd0;
    n_cmp = 0;
    n_err = 0;

    // Reset state on both instances
    #12;
    push(8'h00, 1'b0, 1'b1);
    #1;
    compare({4'b0, seg4}, rdy4, idl4, "rst4");
    push(8'h00, 1'b0, 1'b1);
    compare(seg8, rdy8, idl8, "rst8");
    rn = 1'b1;
    @(posedge clk);
    #1;
    hold4(1, 4'h0, 1'b0, 1'b1, "idle_hold");

    // Ramp up, NSEG=4, DWELL=2
    en4 = 1'b1;
    hold4(3, 4'h1, 1'b0, 1'b0, "up_s1");
    hold4(3, 4'h3, 1'b0, 1'b0, "up_s2");
    hold4(3, 4'h7, 1'b0, 1'b0, "up_s3");
    hold4(3, 4'hF, 1'b0, 1'b0, "up_s4");
    hold4(2, 4'hF, 1'b1, 1'b0, "up_ready");

    // Ramp down from ON
    en4 = 1'b0;
    hold4(3, 4'h7, 1'b0, 1'b0, "dn_s3");
    hold4(3, 4'h3, 1'b0, 1'b0, "dn_s2");
    hold4(3, 4'h1, 1'b0, 1'b0, "dn_s1");
    hold4(3, 4'h0, 1'b0, 1'b0, "dn_s0");
    hold4(2, 4'h0, 1'b0, 1'b1, "dn_idle");

    // Reversal during ramp-up at t+4
    en4 = 1'b1;
    hold4(3, 4'h1, 1'b0, 1'b0, "rv_up1");
    hold4(1, 4'h3, 1'b0, 1'b0, "rv_up2");
    en4 = 1'b0;
    hold4(3, 4'h3, 1'b0, 1'b0, "rv_hold");
    hold4(3, 4'h1, 1'b0, 1'b0, "rv_dn1");
    hold4(3, 4'h0, 1'b0, 1'b0, "rv_dn0");
    hold4(2, 4'h0, 1'b0, 1'b1, "rv_idle");

    // NSEG=8, DWELL=0: one new segment per edge, READY on the ninth edge
    en8 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      m = (1 << i) - 1;
      hold8(1, m[7:0], 1'b0, 1'b0, "d0_up");
    end
    hold8(2, 8'hFF, 1'b1, 1'b0, "d0_ready");

    // DWELL change mid-step applies only from the next reload
    dw8 = 4'd3;
    en8 = 1'b0;
    hold8(2, 8'h7F, 1'b0, 1'b0, "dw_step_a");
    dw8 = 4'd1;
    hold8(2, 8'h7F, 1'b0, 1'b0, "dw_step_b");
    hold8(2, 8'h3F, 1'b0, 1'b0, "dw_new1");
    hold8(2, 8'h1F, 1'b0, 1'b0, "dw_new2");
    hold8(2, 8'h0F, 1'b0, 1'b0, "dw_new3");
    hold8(2, 8'h07, 1'b0, 1'b0, "dw_new4");
    hold8(2, 8'h03, 1'b0, 1'b0, "dw_new5");
    hold8(2, 8'h01, 1'b0, 1'b0, "dw_new6");
    hold8(2, 8'h00, 1'b0, 1'b0, "dw_new7");
    hold8(1, 8'h00, 1'b0, 1'b1, "dw_idle");

    // Asynchronous reset mid-ramp, then restart from segment 0
    en4 = 1'b1;
    hold4(3, 4'h1, 1'b0, 1'b0, "rr_s1");
    hold4(3, 4'h3, 1'b0, 1'b0, "rr_s2");
    hold4(1, 4'h7, 1'b0, 1'b0, "rr_s3");
    #2;
    rn = 1'b0;
    push(8'h00, 1'b0, 1'b1);
    #1;
    compare({4'b0, seg4}, rdy4, idl4, "rr_async");
    @(negedge clk);
    rn = 1'b1;
    hold4(3, 4'h1, 1'b0, 1'b0, "rr_re1");
    hold4(1, 4'h3, 1'b0, 1'b0, "rr_re2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
